// File: rtl/msi_snoop_ctrl.sv
// msi_snoop_ctrl: bus-side MSI snoop responder that borrows the local cache port to flush, downgrade or invalidate.
// Define SNOOP_STATS_EN to add saturating hit/flush/invalidate counters.
module msi_snoop_ctrl #(
    parameter logic [1:0] CORE_ID = 2'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_valid,
    output logic        bus_ready,
    input  logic [1:0]  bus_cmd,
    input  logic [1:0]  bus_src,
    input  logic [10:0] bus_addr,
    output logic        port_req,
    input  logic        port_gnt,
    output logic [10:0] cache_addr,
    output logic        cache_re,
    output logic        cache_we,
    output logic [1:0]  cache_wstate,
    output logic [63:0] cache_wr_data,
    input  logic        cache_hit,
    input  logic [1:0]  cache_rstate,
    input  logic [63:0] cache_rd_data,
    output logic        snp_done,
    output logic        snp_hit,
    output logic        snp_flush,
    output logic        snp_err,
`ifdef SNOOP_STATS_EN
    output logic [15:0] stat_hits,
    output logic [15:0] stat_flushes,
    output logic [15:0] stat_invals,
`endif
    output logic [63:0] flush_data
);
    typedef enum logic [1:0] {INVALID, SHARED, MODIFIED, EXCLUSIVE} blk_state_t;
    typedef enum logic [2:0] {IDLE, ARB, LOOKUP, UPDATE, RESP} st_t;
    localparam logic [1:0] CMD_NONE = 2'b00, CMD_RD = 2'b01, CMD_RDX = 2'b10, CMD_UPGR = 2'b11;

    st_t state, next;
    blk_state_t ws_q, ws_d;
    logic live, acc, hit_d, m, e, s, we_d, flush_d, err_d;
    logic hit_q, flush_q, err_q;
    logic [1:0] cmd_q;
    logic [10:0] addr_q;
    logic [63:0] data_q;

    always_comb begin
        acc = bus_valid && bus_ready;
        hit_d = cache_hit && cache_rstate != INVALID;
        m = hit_d && cache_rstate == MODIFIED;
        e = hit_d && cache_rstate == EXCLUSIVE;
        s = hit_d && cache_rstate == SHARED;
        we_d = cmd_q == CMD_RD ? (m || e) : cmd_q == CMD_RDX ? hit_d : cmd_q == CMD_UPGR ? s : 1'b0;
        ws_d = cmd_q == CMD_RD ? SHARED : INVALID;
        flush_d = (cmd_q == CMD_RD || cmd_q == CMD_RDX) && m;
        err_d = cmd_q == CMD_UPGR && (m || e);
        next = state;
        case (state)
            IDLE:    if (acc) next = (bus_cmd == CMD_NONE || bus_src == CORE_ID) ? RESP : ARB;
            ARB:     if (port_gnt) next = LOOKUP;
            LOOKUP:  next = we_d ? UPDATE : RESP;
            UPDATE:  next = RESP;
            RESP:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            live <= 1'b0;
            port_req <= 1'b0;
            cmd_q <= CMD_NONE;
            addr_q <= '0;
            data_q <= '0;
            ws_q <= INVALID;
            hit_q <= 1'b0;
            flush_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= next;
            live <= 1'b1;
            port_req <= next == ARB || next == LOOKUP || next == UPDATE;
            if (acc) begin
                cmd_q <= bus_cmd;
                addr_q <= bus_addr;
                data_q <= '0;
                hit_q <= 1'b0;
                flush_q <= 1'b0;
                err_q <= 1'b0;
            end
            if (state == LOOKUP) begin
                data_q <= cache_rd_data;
                ws_q <= ws_d;
                hit_q <= hit_d;
                flush_q <= flush_d;
                err_q <= err_d;
            end
        end
    end

    assign bus_ready = live && state == IDLE;
    assign cache_re = state == LOOKUP;
    assign cache_we = state == UPDATE;
    assign cache_addr = (cache_re || cache_we) ? addr_q : '0;
    assign cache_wstate = cache_we ? ws_q : INVALID;
    assign cache_wr_data = cache_we ? data_q : '0;
    assign snp_done = state == RESP;
    assign snp_hit = snp_done && hit_q;
    assign snp_flush = snp_done && flush_q;
    assign snp_err = snp_done && err_q;
    assign flush_data = snp_flush ? data_q : '0;

`ifdef SNOOP_STATS_EN
    logic inval_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inval_q <= 1'b0;
            stat_hits <= '0;
            stat_flushes <= '0;
            stat_invals <= '0;
        end else begin
            if (acc) inval_q <= 1'b0;
            if (state == LOOKUP) inval_q <= we_d && ws_d == INVALID;
            if (snp_done) begin
                if (hit_q && stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
                if (flush_q && stat_flushes != 16'hFFFF) stat_flushes <= stat_flushes + 16'd1;
                if (inval_q && stat_invals != 16'hFFFF) stat_invals <= stat_invals + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_msi_snoop_ctrl.sv
// tb_msi_snoop_ctrl: table-driven snoop vectors against a small cache array model, plus stall and reset sequences.
module tb_msi_snoop_ctrl;
    localparam logic [1:0] I = 2'd0, S = 2'd1, M = 2'd2, E = 2'd3;
    localparam logic [1:0] NONE = 2'b00, RD = 2'b01, RDX = 2'b10, UPGR = 2'b11;

    logic clk = 0, rst_n = 0, bus_valid = 0, port_gnt = 1;
    logic [1:0] bus_cmd = 0, bus_src = 0;
    logic [10:0] bus_addr = 0;
    logic bus_ready, port_req, cache_re, cache_we, cache_hit;
    logic [10:0] cache_addr;
    logic [1:0] cache_wstate, cache_rstate;
    logic [63:0] cache_wr_data, cache_rd_data, flush_data;
    logic snp_done, snp_hit, snp_flush, snp_err;
`ifdef SNOOP_STATS_EN
    logic [15:0] stat_hits, stat_flushes, stat_invals;
`endif

    msi_snoop_ctrl #(.CORE_ID(2'd0)) dut (
        .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_cmd(bus_cmd), .bus_src(bus_src), .bus_addr(bus_addr),
        .port_req(port_req), .port_gnt(port_gnt), .cache_addr(cache_addr),
        .cache_re(cache_re), .cache_we(cache_we), .cache_wstate(cache_wstate),
        .cache_wr_data(cache_wr_data), .cache_hit(cache_hit), .cache_rstate(cache_rstate),
        .cache_rd_data(cache_rd_data), .snp_done(snp_done), .snp_hit(snp_hit),
        .snp_flush(snp_flush), .snp_err(snp_err),
`ifdef SNOOP_STATS_EN
        .stat_hits(stat_hits), .stat_flushes(stat_flushes), .stat_invals(stat_invals),
`endif
        .flush_data(flush_data)
    );

    always #5 clk = ~clk;

    // Cache array model: read combinationally, written in tick() on the edge that closes a cache_we cycle
    logic [1:0] mst [2048];
    logic [63:0] mdat [2048];
    assign cache_rstate = mst[cache_addr];
    assign cache_hit = mst[cache_addr] != I;
    assign cache_rd_data = mdat[cache_addr];

    int pass_cnt = 0, total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic tick();
        logic wr;
        logic [10:0] a;
        logic [1:0] ws;
        logic [63:0] d;
        wr = cache_we; a = cache_addr; ws = cache_wstate; d = cache_wr_data;
        @(posedge clk);
        if (wr === 1'b1) begin mst[a] = ws; mdat[a] = d; end
        #1;
    endtask

    typedef struct {
        logic [1:0] cmd, src;
        logic [10:0] addr;
        logic [1:0] pre;
        logic [63:0] dat;
        int lat;
        logic we;
        logic [1:0] ws;
        logic hit, flush, err;
        logic [1:0] post;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] cmd, src, input logic [10:0] addr, input logic [1:0] pre,
                                input logic [63:0] dat, input int lat, input logic we, input logic [1:0] ws,
                                input logic hit, flush, err, input logic [1:0] post);
        vec_t v;
        v.cmd = cmd; v.src = src; v.addr = addr; v.pre = pre; v.dat = dat; v.lat = lat; v.we = we;
        v.ws = ws; v.hit = hit; v.flush = flush; v.err = err; v.post = post;
        return v;
    endfunction

    task automatic accept(input logic [1:0] cmd, src, input logic [10:0] addr);
        int w;
        w = 0;
        while (bus_ready !== 1'b1 && w < 10) begin tick(); w++; end
        if (bus_ready !== 1'b1) chk("ready_timeout", {63'd0, bus_ready}, 64'd1);
        bus_valid = 1; bus_cmd = cmd; bus_src = src; bus_addr = addr;
        tick();
        bus_valid = 0; bus_cmd = NONE; bus_src = 0; bus_addr = 0;
    endtask

    task automatic run(input vec_t v, input int idx);
        int lat, nwe, nre;
        logic bad, req_seen;
        logic [1:0] ws_seen;
        logic [63:0] wd_seen;
        mst[v.addr] = v.pre; mdat[v.addr] = v.dat;
        accept(v.cmd, v.src, v.addr);
        lat = 1; nwe = 0; nre = 0; bad = 0; req_seen = 0; ws_seen = 0; wd_seen = 0;
        while (snp_done !== 1'b1 && lat < 12) begin
            if (cache_we) begin nwe++; ws_seen = cache_wstate; wd_seen = cache_wr_data; end
            if (cache_re) nre++;
            if (port_req) req_seen = 1;
            if ((cache_re && cache_we) || ((cache_re || cache_we) && !port_req) || bus_ready) bad = 1;
            tick(); lat++;
        end
        chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        chk($sformatf("v%0d flags hit/flush/err", idx), {61'd0, snp_hit, snp_flush, snp_err},
            {61'd0, v.hit, v.flush, v.err});
        chk($sformatf("v%0d flush_data", idx), flush_data, v.flush ? v.dat : 64'd0);
        chk($sformatf("v%0d write count", idx), 64'(nwe), {63'd0, v.we});
        if (v.we) chk($sformatf("v%0d write state/data", idx), {ws_seen, wd_seen[61:0]}, {v.ws, v.dat[61:0]});
        chk($sformatf("v%0d read count", idx), 64'(nre), (v.lat > 1) ? 64'd1 : 64'd0);
        chk($sformatf("v%0d port_req seen", idx), {63'd0, req_seen}, (v.lat > 1) ? 64'd1 : 64'd0);
        chk($sformatf("v%0d resp ready/req/bad", idx), {61'd0, bus_ready, port_req, bad}, 64'd0);
        tick();
        chk($sformatf("v%0d line state after", idx), {62'd0, mst[v.addr]}, {62'd0, v.post});
        chk($sformatf("v%0d done is one cycle", idx), {63'd0, snp_done}, 64'd0);
    endtask

    vec_t vecs[13];

    initial begin
        for (int i = 0; i < 2048; i++) begin mst[i] = I; mdat[i] = 64'd0; end
        vecs[0]  = mk(RD,   2'd1, 11'h0C5, M, 64'hDEAD_BEEF_0123_4567, 4, 1, S, 1, 1, 0, S);
        vecs[1]  = mk(RDX,  2'd2, 11'h012, S, 64'h1111_2222_3333_4444, 4, 1, I, 1, 0, 0, I);
        vecs[2]  = mk(RD,   2'd3, 11'h012, I, 64'h1111_2222_3333_4444, 3, 0, I, 0, 0, 0, I);
        vecs[3]  = mk(RDX,  2'd0, 11'h040, M, 64'hAAAA_0000_BBBB_0001, 1, 0, I, 0, 0, 0, M);
        vecs[4]  = mk(UPGR, 2'd1, 11'h7FF, M, 64'h0F0F_0F0F_0F0F_0F0F, 3, 0, I, 1, 0, 1, M);
        vecs[5]  = mk(RD,   2'd2, 11'h001, E, 64'h5555_6666_7777_8888, 4, 1, S, 1, 0, 0, S);
        vecs[6]  = mk(RD,   2'd3, 11'h100, S, 64'h0000_0000_0000_0ABC, 3, 0, I, 1, 0, 0, S);
        vecs[7]  = mk(RDX,  2'd1, 11'h200, M, 64'hCAFE_F00D_1234_5678, 4, 1, I, 1, 1, 0, I);
        vecs[8]  = mk(UPGR, 2'd2, 11'h3A5, S, 64'h9999_8888_7777_6666, 4, 1, I, 1, 0, 0, I);
        vecs[9]  = mk(UPGR, 2'd3, 11'h3A6, E, 64'h1234_0000_0000_4321, 3, 0, I, 1, 0, 1, E);
        vecs[10] = mk(NONE, 2'd1, 11'h0C5, S, 64'h0000_0000_0000_0001, 1, 0, I, 0, 0, 0, S);
        vecs[11] = mk(RDX,  2'd3, 11'h555, E, 64'hFEDC_BA98_7654_3210, 4, 1, I, 1, 0, 0, I);
        vecs[12] = mk(UPGR, 2'd1, 11'h556, I, 64'h0, 3, 0, I, 0, 0, 0, I);

        // Reset state and ready rising in the first cycle after release
        tick(); tick();
        chk("reset outputs", {58'd0, bus_ready, port_req, cache_re, cache_we, snp_done, snp_err}, 64'd0);
        chk("reset flush_data", flush_data, 64'd0);
        rst_n = 1;
        chk("ready low before first edge", {63'd0, bus_ready}, 64'd0);
        tick();
        chk("ready after release", {63'd0, bus_ready}, 64'd1);

        for (int i = 0; i < 13; i++) run(vecs[i], i);

        // Grant held low for five cycles, then the normal flush sequence
        port_gnt = 0;
        mst[11'h2C3] = M; mdat[11'h2C3] = 64'h0123_4567_89AB_CDEF;
        accept(RD, 2'd1, 11'h2C3);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall c%0d req/re/ready", c), {61'd0, port_req, cache_re, bus_ready}, 64'd4);
            tick();
        end
        port_gnt = 1;
        tick();
        chk("stall lookup re", {62'd0, cache_re, port_req}, 64'd3);
        tick();
        chk("stall update we/state", {cache_we, 61'd0, cache_wstate}, {1'b1, 61'd0, S});
        port_gnt = 0;
        tick();
        chk("stall resp done/flush", {62'd0, snp_done, snp_flush}, 64'd3);
        chk("stall flush_data", flush_data, 64'h0123_4567_89AB_CDEF);
        port_gnt = 1;
        tick();

        // Reset pulsed during UPDATE abandons the write
        mst[11'h0AA] = E; mdat[11'h0AA] = 64'h7777_0000_0000_7777;
        accept(RD, 2'd2, 11'h0AA);
        tick();
        tick();
        chk("pre-reset in update", {63'd0, cache_we}, 64'd1);
        rst_n = 0;
        #1;
        chk("mid reset outputs", {59'd0, cache_we, port_req, bus_ready, snp_done, cache_re}, 64'd0);
        chk("mid reset wr_data", cache_wr_data, 64'd0);
        tick();
        chk("held reset no done", {62'd0, snp_done, bus_ready}, 64'd0);
        rst_n = 1;
        tick();
        chk("ready after mid reset", {63'd0, bus_ready}, 64'd1);
        chk("line unwritten", {62'd0, mst[11'h0AA]}, {62'd0, E});

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
